// File: rtl/fp16_mult_rr_sched.sv
// Round-robin arbiter that shares one registered fp16 multiplier among NUM_REQ requesters.
// Requester IDs travel alongside the multiplier so each product comes back tagged with its owner.
module fp16_mult_rr_sched #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MULT_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [15:0]           mult_a,
    output logic [15:0]           mult_b,
    input  logic [15:0]           mult_c,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_data,
    output logic                  busy,
    output logic [31:0]           issue_cnt
);

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic                transfer;
    logic                swap;
    logic [15:0]         sel_a;
    logic [15:0]         sel_b;
    int                  idx;

    logic                issue_valid;
    logic [ID_W-1:0]     issue_id;
    logic [MULT_LAT-1:0] stage_valid;
    logic [ID_W-1:0]     stage_id [MULT_LAT];

    // Search begins one past the last winner, so the previous winner has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sel_a  = '0;
        sel_b  = '0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
                sel_a  = req_a[16*idx +: 16];
                sel_b  = req_b[16*idx +: 16];
            end
        end
        transfer  = en && found && !rst;
        req_ready = '0;
        if (transfer) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Only the A port of the multiplier detects zero, so a lone zero on B is moved to A.
    assign swap = (sel_b[14:0] == 15'd0) && (sel_a[14:0] != 15'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= ID_W'(NUM_REQ - 1);
            mult_a      <= '0;
            mult_b      <= '0;
            issue_valid <= 1'b0;
            issue_id    <= '0;
            issue_cnt   <= '0;
        end else begin
            issue_valid <= transfer;
            if (transfer) begin
                ptr       <= winner;
                issue_id  <= winner;
                mult_a    <= swap ? sel_b : sel_a;
                mult_b    <= swap ? sel_a : sel_b;
                issue_cnt <= issue_cnt + 32'd1;
            end
        end
    end

    // Tag pipe advances every cycle regardless of en so in-flight results always drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
            for (int j = 0; j < MULT_LAT; j++) begin
                stage_id[j] <= '0;
            end
        end else begin
            stage_valid[0] <= issue_valid;
            stage_id[0]    <= issue_id;
            for (int j = 1; j < MULT_LAT; j++) begin
                stage_valid[j] <= stage_valid[j-1];
                stage_id[j]    <= stage_id[j-1];
            end
        end
    end

    assign rsp_valid = stage_valid[MULT_LAT-1];
    assign rsp_id    = stage_id[MULT_LAT-1];
    assign rsp_data  = mult_c;
    assign busy      = issue_valid | (|stage_valid);

endmodule
